// File: rtl/mux4_ctrl_pkg.sv
// Shared types and sizes for the round-robin mux4 controller.
// Imported by the picker and the controller top.
package mux4_ctrl_pkg;

    localparam int NREQ   = 4;
    localparam int SEL_W  = 2;
    localparam int HOLD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux44.sv
// 4:1 single-bit mux cell shared by the four requesters.
// Select is {s1, s0}.
module mux44 (
    input  logic [3:0] i,
    input  logic       s0,
    input  logic       s1,
    output logic       y
);

    assign y = i[{s1, s0}];

endmodule

// File: rtl/rr_pick4.sv
// Round-robin picker: first set request after last, wrapping,
// with last itself searched at the end.
module rr_pick4
    import mux4_ctrl_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] cand;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx  = last;
        cand = last;
        for (int k = NREQ; k >= 1; k--) begin
            cand = last + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux4_rr_ctrl.sv
// Round-robin owner sequencer for the shared mux44 cell with a
// one-cycle break-before-make gap and a registered, flagged output.
module mux4_rr_ctrl
    import mux4_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] i,
    output logic [NREQ-1:0] gnt,
    output logic            s1,
    output logic            s0,
    output logic            y_q,
    output logic            y_vld,
    output logic            busy
);

    state_e            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  last_q;
    logic [HOLD_W-1:0] hold_q;

    logic [SEL_W-1:0]  pick;
    logic              any;
    logic              mux_y;
    logic              others;
    logic              hold_max;

    rr_pick4 u_pick (
        .req  (req),
        .last (last_q),
        .idx  (pick),
        .any  (any)
    );

    mux44 u_mux (
        .i  (i),
        .s0 (sel_q[0]),
        .s1 (sel_q[1]),
        .y  (mux_y)
    );

    assign others   = |(req & ~gnt_q);
    assign hold_max = (hold_q == HOLD_W'(HOLD_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(NREQ - 1);
            hold_q  <= '0;
            y_q     <= 1'b0;
            y_vld   <= 1'b0;
        end else begin
            unique case (state_q)
                GRANT: begin
                    y_q   <= mux_y;
                    y_vld <= 1'b1;
                    if (!req[sel_q] || (hold_max && others)) begin
                        state_q <= GAP;
                        gnt_q   <= '0;
                    end else if (!hold_max) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    // IDLE and GAP share the re-arbitration path.
                    y_vld <= 1'b0;
                    if (any) begin
                        state_q <= GRANT;
                        gnt_q   <= onehot(pick);
                        sel_q   <= pick;
                        last_q  <= pick;
                        hold_q  <= HOLD_W'(1);
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign s1   = sel_q[1];
    assign s0   = sel_q[0];
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mux4_rr_ctrl.sv
// Self-checking bench for mux4_rr_ctrl: vector table, rotation
// run and asynchronous reset sequence.
module tb_mux4_rr_ctrl;

    typedef struct {
        logic [3:0] req;
        logic [3:0] i;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       y;
        logic       vld;
        logic       busy;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] i;
    logic [3:0] gnt;
    logic       s1;
    logic       s0;
    logic       y_q;
    logic       y_vld;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    mux4_rr_ctrl #(.HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .i     (i),
        .gnt   (gnt),
        .s1    (s1),
        .s0    (s0),
        .y_q   (y_q),
        .y_vld (y_vld),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] d,
                       input logic [3:0] g, input logic [1:0] s,
                       input logic y, input logic v, input logic b);
        vec_t e;
        e.req = r; e.i = d; e.gnt = g; e.sel = s;
        e.y = y; e.vld = v; e.busy = b;
        tbl.push_back(e);
    endtask

    task automatic drive_push(input vec_t e);
        req = e.req;
        i   = e.i;
        exp_q.push_back(e);
    endtask

    task automatic edge_check(input string tag);
        vec_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 4'd1, 4'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_gnt"}, gnt, e.gnt);
            chk({tag, "_sel"}, {2'b00, s1, s0}, {2'b00, e.sel});
            chk({tag, "_y"}, {3'b000, y_q}, {3'b000, e.y});
            chk({tag, "_vld"}, {3'b000, y_vld}, {3'b000, e.vld});
            chk({tag, "_busy"}, {3'b000, busy}, {3'b000, e.busy});
        end
    endtask

    task automatic step(input vec_t e, input string tag);
        @(negedge clk);
        drive_push(e);
        edge_check(tag);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_gnt"}, gnt, 4'b0000);
        chk({tag, "_sel"}, {2'b00, s1, s0}, 4'b0000);
        chk({tag, "_y"}, {3'b000, y_q}, 4'b0000);
        chk({tag, "_vld"}, {3'b000, y_vld}, 4'b0000);
        chk({tag, "_busy"}, {3'b000, busy}, 4'b0000);
    endtask

    initial begin
        vec_t v;
        logic [3:0] d;
        logic       ey;
        logic [1:0] o;
        // single request, first grant and data
        add(4'b0001, 4'b0001, 4'b0001, 2'd0, 0, 0, 1);
        add(4'b0001, 4'b0001, 4'b0001, 2'd0, 1, 1, 1);
        add(4'b0000, 4'b0001, 4'b0000, 2'd0, 1, 1, 1);
        add(4'b0000, 4'b0001, 4'b0000, 2'd0, 1, 0, 0);
        // lone requester saturates, no gap
        add(4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 0, 1);
        for (int j = 1; j < 10; j++) begin
            d = {1'b0, j[0], 2'b00};
            add(4'b0100, d, 4'b0100, 2'd2, d[2], 1, 1);
        end
        add(4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 1, 1);
        add(4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 0, 0);
        // owner 2 drops with 3 waiting
        add(4'b0100, 4'b0000, 4'b0100, 2'd2, 0, 0, 1);
        add(4'b1100, 4'b0000, 4'b0100, 2'd2, 0, 1, 1);
        add(4'b1100, 4'b0100, 4'b0100, 2'd2, 1, 1, 1);
        add(4'b1000, 4'b0000, 4'b0000, 2'd2, 0, 1, 1);
        add(4'b1000, 4'b1000, 4'b1000, 2'd3, 0, 0, 1);
        add(4'b1000, 4'b1000, 4'b1000, 2'd3, 1, 1, 1);
        add(4'b0000, 4'b0000, 4'b0000, 2'd3, 0, 1, 1);
        add(4'b0000, 4'b0000, 4'b0000, 2'd3, 0, 0, 0);
        // last=1, then wrap past 3 to 0
        add(4'b0010, 4'b0000, 4'b0010, 2'd1, 0, 0, 1);
        add(4'b0000, 4'b0000, 4'b0000, 2'd1, 0, 1, 1);
        add(4'b0000, 4'b0000, 4'b0000, 2'd1, 0, 0, 0);
        add(4'b0101, 4'b0000, 4'b0100, 2'd2, 0, 0, 1);
        add(4'b0001, 4'b0000, 4'b0000, 2'd2, 0, 1, 1);
        add(4'b0001, 4'b0001, 4'b0001, 2'd0, 0, 0, 1);
        add(4'b0001, 4'b0001, 4'b0001, 2'd0, 1, 1, 1);

        rst_n = 1'b0;
        req   = 4'b0000;
        i     = 4'b0000;
        #2;
        reset_check("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < tbl.size(); n++) begin
            step(tbl[n], $sformatf("v%0d", n));
        end

        // asynchronous reset while owner 0 is granted
        #3;
        rst_n = 1'b0;
        #1;
        reset_check("arst");
        @(negedge clk);
        v.req = 4'b1010; v.i = 4'b0010; v.gnt = 4'b0010; v.sel = 2'd1;
        v.y = 0; v.vld = 0; v.busy = 1;
        @(negedge clk);
        rst_n = 1'b1;
        drive_push(v);
        edge_check("arel");
        v.gnt = 4'b0010; v.y = 1; v.vld = 1;
        step(v, "arel2");

        // full contention rotation from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        ey = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            o = 2'((n - 1) / 5);
            d = 4'($urandom_range(0, 15));
            v.req  = 4'b1111;
            v.i    = d;
            v.sel  = o;
            v.gnt  = ((n - 1) % 5 < 4) ? (4'b0001 << o) : 4'b0000;
            v.busy = 1;
            if (n > 1 && ((n - 2) % 5) < 4) begin
                ey    = d[2'((n - 2) / 5)];
                v.vld = 1;
            end else begin
                v.vld = 0;
            end
            v.y = ey;
            step(v, $sformatf("rot%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
